// File: rtl/updown_counter_bank.sv
// Bank of up/down counters with per-channel load, cascade chaining,
// registered terminal-count flags and a snapshot; COUNTER_BANK_SATURATE_EN selects saturation.
module updown_counter_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       direction,
    input  logic                      cascade,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_value,
    input  logic                      capture,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS*WIDTH-1:0] snapshot
);

    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [CHANNELS-1:0][WIDTH-1:0] cnt_q;
    logic [CHANNELS-1:0][WIDTH-1:0] cnt_d;
    logic [CHANNELS-1:0][WIDTH-1:0] nxt;
    logic [CHANNELS-1:0]            tc_q;
    logic [CHANNELS-1:0]            tc_d;
    logic [CHANNELS-1:0]            up;
    logic [CHANNELS-1:0]            at_lim;
    logic [CHANNELS-1:0]            step;
    logic [CHANNELS*WIDTH-1:0]      snap_q;

    // In cascade mode every slice follows channel 0's sense and limit.
    always_comb begin
        up     = '0;
        at_lim = '0;
        nxt    = cnt_q;
        for (int i = 0; i < CHANNELS; i++) begin
            up[i]     = cascade ? direction[0] : direction[i];
            at_lim[i] = up[i] ? (cnt_q[i] == ONES) : (cnt_q[i] == ZERO);
            nxt[i]    = up[i] ? cnt_q[i] + ONE : cnt_q[i] - ONE;
        end
    end

    always_comb begin
        logic chain;
`ifdef COUNTER_BANK_SATURATE_EN
        logic pinned;
        pinned = &at_lim;
`endif
        chain = 1'b1;
        step  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            step[i] = cascade ? (en[0] & chain) : en[i];
            chain   = chain & at_lim[i];
`ifdef COUNTER_BANK_SATURATE_EN
            step[i] = step[i] & ~(cascade ? pinned : at_lim[i]);
`endif
        end
    end

    // Load beats step; carries were already derived from pre-edge values.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (load[i]) begin
                cnt_d[i] = load_value[i*WIDTH +: WIDTH];
            end else if (step[i]) begin
                cnt_d[i] = nxt[i];
`ifdef COUNTER_BANK_SATURATE_EN
                tc_d[i]  = (nxt[i] == (up[i] ? ONES : ZERO));
`else
                tc_d[i]  = at_lim[i];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tc_q   <= '0;
            snap_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            if (capture) begin
                snap_q <= cnt_q;
            end
        end
    end

    assign count    = cnt_q;
    assign tc       = tc_q;
    assign snapshot = snap_q;

endmodule

// File: tb/tb_updown_counter_bank.sv
// Directed vector bench for updown_counter_bank (WIDTH=8, CHANNELS=2).
module tb_updown_counter_bank;

    localparam int W = 8;
    localparam int C = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [C-1:0]   en;
    logic [C-1:0]   direction;
    logic           cascade;
    logic [C-1:0]   load;
    logic [C*W-1:0] load_value;
    logic           capture;
    logic [C*W-1:0] count;
    logic [C-1:0]   tc;
    logic [C*W-1:0] snapshot;

    always #5 clk = ~clk;

    updown_counter_bank #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .direction  (direction),
        .cascade    (cascade),
        .load       (load),
        .load_value (load_value),
        .capture    (capture),
        .count      (count),
        .tc         (tc),
        .snapshot   (snapshot)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  en;
        logic [1:0]  dir;
        logic        casc;
        logic [1:0]  ld;
        logic [15:0] lv;
        logic        cap;
        logic [15:0] ec;
        logic [1:0]  et;
        logic [15:0] es;
    } vec_t;

    vec_t vq[$];
    int   applied     = 0;
    int   miscompares = 0;

    task automatic add(input logic r, input logic [1:0] e, input logic [1:0] d,
                       input logic cs, input logic [1:0] l, input logic [15:0] v,
                       input logic cp, input logic [15:0] ec, input logic [1:0] et,
                       input logic [15:0] es);
        vq.push_back('{r, e, d, cs, l, v, cp, ec, et, es});
    endtask

    task automatic drive(input logic r, input logic [1:0] e, input logic [1:0] d,
                         input logic cs, input logic [1:0] l, input logic [15:0] v,
                         input logic cp);
        reset      = r;
        en         = e;
        direction  = d;
        cascade    = cs;
        load       = l;
        load_value = v;
        capture    = cp;
    endtask

    task automatic check(input string nm, input logic [15:0] ec,
                         input logic [1:0] et, input logic [15:0] es);
        applied++;
        if (count !== ec || tc !== et || snapshot !== es) begin
            miscompares++;
            $display("FAIL %s: got count=%h tc=%b snapshot=%h, required count=%h tc=%b snapshot=%h",
                     nm, count, tc, snapshot, ec, et, es);
        end
    endtask

    task automatic cyc(input string nm, input logic [15:0] ec,
                       input logic [1:0] et, input logic [15:0] es);
        @(posedge clk);
        #1;
        check(nm, ec, et, es);
    endtask

    initial begin
        drive(1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 16'h0000, 1'b0);
        @(posedge clk);
        #1;

`ifndef COUNTER_BANK_SATURATE_EN
        //  rst  en     dir    cs    ld     lv        cp    count     tc     snap
        add(1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000, 2'b00, 16'h0000);
        add(1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000, 2'b00, 16'h0000);
        add(1'b0, 2'b11, 2'b01, 1'b0, 2'b00, 16'h0000, 1'b0, 16'hFF01, 2'b10, 16'h0000);
        add(1'b0, 2'b11, 2'b01, 1'b0, 2'b00, 16'h0000, 1'b0, 16'hFE02, 2'b00, 16'h0000);
        add(1'b0, 2'b11, 2'b01, 1'b0, 2'b00, 16'h0000, 1'b0, 16'hFD03, 2'b00, 16'h0000);
        add(1'b1, 2'b11, 2'b01, 1'b0, 2'b11, 16'h1234, 1'b1, 16'h0000, 2'b00, 16'h0000);
        add(1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 16'h00FE, 1'b0, 16'h00FE, 2'b00, 16'h0000);
        add(1'b0, 2'b01, 2'b01, 1'b0, 2'b00, 16'h0000, 1'b0, 16'h00FF, 2'b00, 16'h0000);
        add(1'b0, 2'b01, 2'b01, 1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000, 2'b01, 16'h0000);
        add(1'b0, 2'b00, 2'b01, 1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000, 2'b00, 16'h0000);
        add(1'b0, 2'b00, 2'b00, 1'b1, 2'b11, 16'h00FF, 1'b0, 16'h00FF, 2'b00, 16'h0000);
        add(1'b0, 2'b01, 2'b01, 1'b1, 2'b00, 16'h0000, 1'b0, 16'h0100, 2'b01, 16'h0000);
        add(1'b0, 2'b00, 2'b00, 1'b1, 2'b11, 16'hFFFF, 1'b0, 16'hFFFF, 2'b00, 16'h0000);
        add(1'b0, 2'b01, 2'b01, 1'b1, 2'b00, 16'h0000, 1'b0, 16'h0000, 2'b11, 16'h0000);
        add(1'b0, 2'b01, 2'b00, 1'b1, 2'b00, 16'h0000, 1'b0, 16'hFFFF, 2'b11, 16'h0000);
        add(1'b0, 2'b11, 2'b10, 1'b1, 2'b00, 16'h0000, 1'b0, 16'hFFFE, 2'b00, 16'h0000);
        add(1'b0, 2'b01, 2'b01, 1'b0, 2'b01, 16'h005A, 1'b0, 16'hFF5A, 2'b00, 16'h0000);
        add(1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 16'h00FF, 1'b0, 16'hFFFF, 2'b00, 16'h0000);
        add(1'b0, 2'b01, 2'b01, 1'b0, 2'b01, 16'h0033, 1'b0, 16'hFF33, 2'b00, 16'h0000);
        add(1'b0, 2'b00, 2'b00, 1'b0, 2'b11, 16'h01FE, 1'b0, 16'h01FE, 2'b00, 16'h0000);
        add(1'b0, 2'b01, 2'b01, 1'b1, 2'b00, 16'h0000, 1'b0, 16'h01FF, 2'b00, 16'h0000);
        add(1'b0, 2'b01, 2'b01, 1'b1, 2'b00, 16'h0000, 1'b1, 16'h0200, 2'b01, 16'h01FF);
        add(1'b0, 2'b01, 2'b01, 1'b1, 2'b00, 16'h0000, 1'b0, 16'h0201, 2'b00, 16'h01FF);
        add(1'b0, 2'b00, 2'b01, 1'b1, 2'b00, 16'h0000, 1'b0, 16'h0201, 2'b00, 16'h01FF);
        add(1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 16'h00FF, 1'b0, 16'h02FF, 2'b00, 16'h01FF);
        add(1'b1, 2'b01, 2'b01, 1'b0, 2'b00, 16'h0000, 1'b1, 16'h0000, 2'b00, 16'h0000);
        add(1'b0, 2'b00, 2'b00, 1'b0, 2'b11, 16'h10FF, 1'b0, 16'h10FF, 2'b00, 16'h0000);
        add(1'b0, 2'b01, 2'b01, 1'b0, 2'b00, 16'h0000, 1'b0, 16'h1000, 2'b01, 16'h0000);
        add(1'b0, 2'b00, 2'b00, 1'b0, 2'b11, 16'h10FF, 1'b0, 16'h10FF, 2'b00, 16'h0000);
        add(1'b0, 2'b01, 2'b01, 1'b1, 2'b00, 16'h0000, 1'b0, 16'h1100, 2'b01, 16'h0000);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].en, vq[i].dir, vq[i].casc,
                  vq[i].ld, vq[i].lv, vq[i].cap);
            cyc($sformatf("vec%0d", i), vq[i].ec, vq[i].et, vq[i].es);
        end
`endif

        // Snapshot holds while counting continues.
        @(negedge clk);
        drive(1'b0, 2'b00, 2'b00, 1'b0, 2'b11, 16'hABCD, 1'b0);
        cyc("load_abcd", 16'hABCD, 2'b00, 16'h0000);
        @(negedge clk);
        drive(1'b0, 2'b11, 2'b11, 1'b0, 2'b00, 16'h0000, 1'b1);
        cyc("cap_abcd", 16'hACCE, 2'b00, 16'hABCD);
        @(negedge clk);
        capture = 1'b0;
        cyc("hold1", 16'hADCF, 2'b00, 16'hABCD);
        cyc("hold2", 16'hAED0, 2'b00, 16'hABCD);
        cyc("hold3", 16'hAFD1, 2'b00, 16'hABCD);

        // Reset acts only on an edge.
        @(negedge clk);
        drive(1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 16'h0000, 1'b0);
        #1;
        check("rst_before_edge", 16'hAFD1, 2'b00, 16'hABCD);
        cyc("rst_at_edge", 16'h0000, 2'b00, 16'h0000);

`ifdef COUNTER_BANK_SATURATE_EN
        @(negedge clk);
        drive(1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 16'h00FE, 1'b0);
        cyc("sat_load", 16'h00FE, 2'b00, 16'h0000);
        @(negedge clk);
        drive(1'b0, 2'b01, 2'b01, 1'b0, 2'b00, 16'h0000, 1'b0);
        cyc("sat_up1", 16'h00FF, 2'b01, 16'h0000);
        cyc("sat_up2", 16'h00FF, 2'b00, 16'h0000);
        cyc("sat_up3", 16'h00FF, 2'b00, 16'h0000);
        @(negedge clk);
        direction = 2'b00;
        cyc("sat_down", 16'h00FE, 2'b00, 16'h0000);
        @(negedge clk);
        drive(1'b0, 2'b00, 2'b00, 1'b1, 2'b11, 16'hFFFE, 1'b0);
        cyc("sat_cload", 16'hFFFE, 2'b00, 16'h0000);
        @(negedge clk);
        drive(1'b0, 2'b01, 2'b01, 1'b1, 2'b00, 16'h0000, 1'b0);
        cyc("sat_cup1", 16'hFFFF, 2'b01, 16'h0000);
        cyc("sat_cup2", 16'hFFFF, 2'b00, 16'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/updown_counter_bank.md
# updown_counter_bank

Parametrised bank of CHANNELS synchronous up/down counters, each WIDTH bits, with per-channel enable, direction and parallel load. A cascade mode chains all channels into one CHANNELS*WIDTH-bit counter. Registered terminal-count flags and a coherent snapshot register are provided. It is the generalised replacement for the fixed 8/16-bit counter top, feeding the same downstream count buses.

## Interface
- WIDTH, 8: bits per channel; at least 2.
- CHANNELS, 2: number of channels; at least 1.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- en  in  CHANNELS  per-channel count enable. Ignored for channels above 0 in cascade mode.
- direction  in  CHANNELS  1 = up, 0 = down. Ignored for channels above 0 in cascade mode.
- cascade  in  1  1 = chain channels; channel 0 is the LSB slice.
- load  in  CHANNELS  per-channel parallel load strobe.
- load_value  in  CHANNELS*WIDTH  load data; channel i is bits [i*WIDTH +: WIDTH].
- capture  in  1  snapshot strobe.
- count  out  CHANNELS*WIDTH  live counter registers; channel i is bits [i*WIDTH +: WIDTH].
- tc  out  CHANNELS  registered terminal-count pulse per channel.
- snapshot  out  CHANNELS*WIDTH  captured copy of count.

## Operation
- Per-channel priority: reset, then load, then step, then hold.
- Independent mode (cascade=0):
  - Channel i steps by ±1 when en[i]=1.
  - Arithmetic is modulo 2^WIDTH.
- Cascade mode (cascade=1):
  - Channel 0 steps when en[0]=1, direction[0] gives the sense.
  - Channel i>0 steps with the same sense when channel 0 steps and every lower channel currently holds the limit value. The limit is all-ones when counting up and all-zeros when counting down.
  - Carry evaluation uses the pre-edge register values.
  - A channel with load[i]=1 takes load_value and does not step. Carry into higher channels is still computed from the pre-edge values.
- tc[i] is 1 for exactly one cycle, in the same cycle count first shows the post-step value, when channel i stepped across its boundary: up from all-ones to 0, or down from 0 to all-ones. A load never sets tc.
- In cascade mode, full-chain wrap asserts every tc bit simultaneously. The top tc bit is the wide-counter rollover.
- capture=1: snapshot takes the whole pre-edge count on the next edge. All channels are sampled at once, so the value is tear-free in cascade mode. snapshot holds its value otherwise.
- Changing cascade mid-run takes effect on the next edge. Register contents are preserved.

## Timing
- All outputs are registered. Latency from any input to its effect is 1 clk.
- Reset values: count = 0, tc = 0, snapshot = 0.
- Reset asserted mid-count: all outputs are 0 on the following edge; load and capture are ignored that cycle.
- Reset has no effect while asserted until a clk edge arrives.
- Load and step of the same channel in the same cycle: the load wins, and tc[i] = 0.
- Capture in the same cycle as a step: snapshot gets the pre-step value.
- Capture in the same cycle as reset: snapshot = 0.
- In independent mode, en[i]=0 holds channel i, and tc[i] = 0 the next cycle.

## Configuration
- COUNTER_BANK_SATURATE_EN defined:
  - Counters saturate instead of wrapping. Up holds at all-ones; down holds at 0.
  - In cascade mode saturation applies to the whole chain: the chain holds at all-ones or all-zeros, and lower slices do not wrap while the chain is pinned.
  - tc[i] pulses for one cycle on the step that reaches the limit. No repeat while held at the limit.
  - A step away from the limit resumes normal counting.
- COUNTER_BANK_SATURATE_EN undefined:
  - Modulo wrap as described under Operation.
  - No saturation logic is synthesised.

## Test plan
- Reset and count up:
  - Stimulus: WIDTH=8, CHANNELS=2, cascade=0. Reset 2 cycles, then en=2'b11, direction=2'b01 for 3 cycles.
  - Required: count = 16'hFD03.
  - Reset during counting: count = 0 and tc = 0 one edge later.
- Independent wrap:
  - Stimulus: load ch0 = 8'hFE, then step up 2 cycles.
  - Required: ch0 goes FF, then 00. tc[0] = 1 only in the 00 cycle. ch1 unchanged.
- Cascade carry:
  - Stimulus: load count = 16'h00FF, cascade=1, one up step.
  - Required: 16'h0100; tc = 2'b01.
  - From 16'hFFFF, one up step: 16'h0000, tc = 2'b11.
  - Repeat downward from 16'h0000: 16'hFFFF, tc = 2'b11.
- Load/step collision:
  - Stimulus: en[0]=1 and load[0]=1 with load_value 8'h5A in the same cycle.
  - Required: ch0 = 5A, tc[0] = 0.
- Snapshot coherence:
  - Stimulus: cascade counting, capture in the cycle count = 16'h01FF.
  - Required: snapshot = 16'h01FF while count shows 16'h0200; snapshot then holds.
- Saturation (build with COUNTER_BANK_SATURATE_EN):
  - Stimulus: from 8'hFE, step up 3 cycles.
  - Required: FF, FF, FF with a single tc pulse.
  - Stimulus: one down step from FF.
  - Required: FE.
